// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module   : uart_tx_arbiter
//  Brief    : Round-robin packet arbiter sharing one UART transmitter between
//             N_REQ byte-stream requesters. Optional owner timeout is built
//             when UART_TX_ARB_TIMEOUT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int N_REQ          = 3,
    parameter int MAX_PKT_BYTES  = 64,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         byte_valid,
    input  logic [8*N_REQ-1:0]       byte_data,
    input  logic [N_REQ-1:0]         byte_last,
    output logic [N_REQ-1:0]         byte_ready,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner_id,
    output logic                     arb_busy,
    output logic [7:0]               tx_data,
    output logic                     tx_send,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     timeout_pulse
);

    localparam int c_OW = $clog2(N_REQ);
    localparam int c_CW = (MAX_PKT_BYTES > 0) ? $clog2(MAX_PKT_BYTES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_OWN       = 2'd1,
        S_SEND      = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [c_OW-1:0]   owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_send_q, tx_send_d;
    logic [c_OW-1:0]   last_owner_q, last_owner_d;
    logic              last_byte_q, last_byte_d;
    logic [c_CW-1:0]   cnt_q, cnt_d;

    logic              w_pick_found;
    logic [c_OW-1:0]   w_pick_idx;
    logic              w_release;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TW-1:0]   tmo_q, tmo_d;
    logic              timeout_q, timeout_d;
`else
    logic              w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Search upward from the slot after the previous owner, wrapping at N_REQ.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_pick_found && req[(int'(last_owner_q) + k) % N_REQ]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = c_OW'((int'(last_owner_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
        tx_data_d    = tx_data_q;
        tx_send_d    = 1'b0;
        last_owner_d = last_owner_q;
        last_byte_d  = last_byte_q;
        cnt_d        = cnt_q;
        w_release    = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        tmo_d        = '0;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_pick_found) begin
                    state_d = S_OWN;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                    owner_d = w_pick_idx;
                    busy_d  = 1'b1;
                end
            end
            S_OWN: begin
                if (byte_valid[owner_q]) begin
                    tx_data_d   = byte_data[8*owner_q +: 8];
                    last_byte_d = byte_last[owner_q];
                    cnt_d       = cnt_q + 1'b1;
                    state_d     = S_SEND;
                end else if (!req[owner_q]) begin
                    w_release = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
                end else if (tmo_q == c_TW'(TIMEOUT_CYCLES - 1)) begin
                    w_release = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_send_d = 1'b1;
                    state_d   = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    if (last_byte_q ||
                        ((MAX_PKT_BYTES != 0) && (cnt_q == c_CW'(MAX_PKT_BYTES)))) begin
                        w_release = 1'b1;
                    end else begin
                        state_d = S_OWN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every release path (end of packet, cap, req drop, timeout) lands here.
        if (w_release) begin
            state_d      = S_IDLE;
            grant_d      = '0;
            owner_d      = '0;
            busy_d       = 1'b0;
            last_owner_d = owner_q;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            busy_q       <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_send_q    <= 1'b0;
            last_owner_q <= c_OW'(N_REQ - 1);
            last_byte_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            tx_data_q    <= tx_data_d;
            tx_send_q    <= tx_send_d;
            last_owner_q <= last_owner_d;
            last_byte_q  <= last_byte_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout_pulse = timeout_q;
`else
    assign timeout_pulse = 1'b0;
`endif

    for (genvar i = 0; i < N_REQ; i++) begin : g_ready
        assign byte_ready[i] = (state_q == S_OWN) && (owner_q == c_OW'(i));
    end

    assign grant    = grant_q;
    assign owner_id = owner_q;
    assign arb_busy = busy_q;
    assign tx_data  = tx_data_q;
    assign tx_send  = tx_send_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Brief    : Self-checking bench for uart_tx_arbiter with a packet-level
//             round-robin reference model and a frame-timed transmitter model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int N     = 3;
    localparam int CAP   = 4;
    localparam int TMO   = 10;
    localparam int FRAME = 20;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, byte_valid, byte_last, byte_ready, grant;
    logic [8*N-1:0] byte_data;
    logic [1:0]     owner_id;
    logic           arb_busy, tx_send, tx_busy, tx_done, timeout_pulse;
    logic [7:0]     tx_data;

    always #10 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .MAX_PKT_BYTES(CAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
        .grant(grant), .owner_id(owner_id), .arb_busy(arb_busy),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .tx_done(tx_done), .timeout_pulse(timeout_pulse)
    );

    int tests = 0;
    int fails = 0;

    // Pending bytes per requester: {id[1:0], last, data}
    logic [10:0] src_q[$];
    logic [9:0]  log_q[$];
    logic [9:0]  exp_q[$];
    bit          rel_q[$];
    int          m_last, frame_cnt, off_id, off_idx, g_cnt;
    bit          force_busy, pend_chk, pend_rel, inv_err, prev_send, flag;
    logic [N-1:0] hold;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_of(input int id);
        for (int k = 0; k < src_q.size(); k++)
            if (int'(src_q[k][10:9]) == id) return k;
        return -1;
    endfunction

    // Packet-level model: round-robin grants, each grant sends up to CAP bytes
    // or to the end of the packet / end of the requester's data.
    task automatic model_build();
        logic [10:0] m[$];
        m = src_q;
        while (m.size() > 0) begin
            int w;
            int cnt;
            bit done;
            w = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (w < 0)
                    foreach (m[j]) if (w < 0 && int'(m[j][10:9]) == c) w = c;
            end
            cnt  = 0;
            done = 0;
            while (!done) begin
                int idx;
                bit more;
                idx = -1;
                foreach (m[j]) if (idx < 0 && int'(m[j][10:9]) == w) idx = j;
                exp_q.push_back({2'(w), m[idx][7:0]});
                cnt++;
                done = m[idx][8] || (cnt == CAP);
                m.delete(idx);
                more = 0;
                foreach (m[j]) if (int'(m[j][10:9]) == w) more = 1;
                if (!more) done = 1;
            end
            m_last = w;
        end
    endtask

    task automatic tx_step();
        if (pend_chk) begin
            pend_chk = 0;
            if (pend_rel) chk("release_after_done", 32'({grant, arb_busy}), 32'd0);
            else          chk("hold_after_done", 32'(arb_busy), 32'd1);
        end
        tx_done = 1'b0;
        if (tx_send === 1'b1 && frame_cnt > 0) inv_err = 1;
        if (force_busy) begin
            tx_busy = 1'b1;
        end else if (frame_cnt > 0) begin
            frame_cnt--;
            if (frame_cnt == 0) begin
                tx_busy = 1'b0;
                tx_done = 1'b1;
                if (rel_q.size() > 0) begin
                    pend_chk = 1;
                    pend_rel = rel_q.pop_front();
                end
            end
        end else if (tx_send === 1'b1) begin
            tx_busy   = 1'b1;
            frame_cnt = FRAME;
            log_q.push_back({owner_id, tx_data});
        end else begin
            tx_busy = 1'b0;
        end
    endtask

    task automatic req_step();
        if (!arb_busy) g_cnt = 0;
        if (off_id >= 0) begin
            logic [10:0] e;
            e = src_q[off_idx];
            src_q.delete(off_idx);
            g_cnt++;
            rel_q.push_back(e[8] || (g_cnt == CAP));
            off_id = -1;
        end
        for (int i = 0; i < N; i++) begin
            int idx;
            idx    = first_of(i);
            req[i] = (idx >= 0);
            if (idx >= 0 && !hold[i] && $urandom_range(0, 3) != 0) begin
                byte_valid[i]      = 1'b1;
                byte_data[8*i +: 8] = src_q[idx][7:0];
                byte_last[i]       = src_q[idx][8];
                if (byte_ready[i]) begin
                    off_id  = i;
                    off_idx = idx;
                end
            end else begin
                byte_valid[i]       = 1'b0;
                byte_data[8*i +: 8] = 8'($urandom);
                byte_last[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] eg;
        @(negedge clk);
        eg = arb_busy ? (N'(1) << owner_id) : '0;
        if (grant !== eg || (!arb_busy && owner_id !== 2'd0)) inv_err = 1;
        if (tx_send && prev_send) inv_err = 1;
        prev_send = tx_send;
        tx_step();
        req_step();
    endtask

    task automatic push_bytes(input int id, input int n, input logic [7:0] first, input bit with_last);
        for (int b = 0; b < n; b++)
            src_q.push_back({2'(id), (with_last && b == n-1), 8'(first + 8'(b))});
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(src_q.size() == 0 && frame_cnt == 0 && !arb_busy && off_id < 0) && n < budget);
        chk({tag, "_drained"}, 32'(n < budget), 32'd1);
    endtask

    task automatic cmp_log(input string tag);
        int n;
        chk({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) chk({tag, "_frame"}, 32'(log_q[k]), 32'(exp_q[k]));
        chk({tag, "_invariants"}, 32'(inv_err), 32'd0);
        inv_err = 0;
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic scenario(input string tag);
        model_build();
        run_idle(tag, 6000);
        cmp_log(tag);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = '0; byte_valid = '0; byte_last = '0; byte_data = '0;
        tx_busy = 1'b0; tx_done = 1'b0;
        frame_cnt = 0; off_id = -1; off_idx = 0; g_cnt = 0; m_last = N - 1;
        force_busy = 0; pend_chk = 0; pend_rel = 0; inv_err = 0; prev_send = 0; hold = '0;

        // Reset values
        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_owner", 32'(owner_id), 32'd0);
        chk("rst_busy", 32'(arb_busy), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_send", 32'(tx_send), 32'd0);
        chk("rst_timeout", 32'(timeout_pulse), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        reset = 1'b0;

        // Single 3-byte packet from requester 0
        push_bytes(0, 3, 8'h41, 1);
        scenario("single_pkt");

        // Round-robin ordering
        push_bytes(0, 1, 8'h10, 1); push_bytes(2, 1, 8'h12, 1);
        scenario("rr_0_2");
        push_bytes(0, 1, 8'h20, 1); push_bytes(1, 1, 8'h21, 1);
        scenario("rr_0_1");
        push_bytes(0, 1, 8'h30, 1); push_bytes(2, 1, 8'h32, 1);
        scenario("rr_2_0");

        // Fairness cap: 6 bytes with no last while requester 2 waits
        push_bytes(1, 6, 8'hA0, 0); push_bytes(2, 2, 8'hB0, 1);
        scenario("cap");

        // Transmitter busy stall
        force_busy = 1;
        push_bytes(0, 1, 8'h5A, 1);
        model_build();
        for (int n = 0; n < 50 && src_q.size() != 0; n++) tick();
        chk("stall_in_send", 32'(tx_data), 32'h5A);
        flag = 0;
        repeat (100) begin
            tick();
            if (tx_send !== 1'b0 || tx_data !== 8'h5A) flag = 1;
        end
        chk("stall_hold", 32'(flag), 32'd0);
        force_busy = 0;
        tick();
        chk("stall_no_early_send", 32'(tx_send), 32'd0);
        tick();
        chk("stall_send_pulse", 32'(tx_send), 32'd1);
        tick();
        chk("stall_send_single", 32'(tx_send), 32'd0);
        run_idle("stall", 500);
        cmp_log("stall");

        // Reset during WAIT_DONE of owner 1
        push_bytes(1, 3, 8'hC0, 1);
        flag = 0;
        for (int n = 0; n < 200 && !flag; n++) begin
            tick();
            if (tx_send === 1'b1 && owner_id === 2'd1) flag = 1;
        end
        chk("rst_mid_reached", 32'(flag), 32'd1);
        reset = 1'b1;
        src_q.delete(); rel_q.delete(); pend_chk = 0; off_id = -1; g_cnt = 0;
        tick();
        reset = 1'b0;
        chk("rst_mid_grant", 32'(grant), 32'd0);
        chk("rst_mid_send", 32'(tx_send), 32'd0);
        chk("rst_mid_busy", 32'(arb_busy), 32'd0);
        for (int n = 0; n < 40 && frame_cnt != 0; n++) tick();
        log_q.delete(); exp_q.delete(); inv_err = 0;
        m_last = N - 1;
        push_bytes(0, 1, 8'hD0, 1); push_bytes(1, 1, 8'hD1, 1);
        scenario("after_rst");

        // Owner 2 holds req without presenting a byte
        hold = 3'b100;
        push_bytes(2, 1, 8'h77, 1);
        model_build();
        for (int n = 0; n < 20 && !arb_busy; n++) tick();
        chk("hold_owner", 32'(owner_id), 32'd2);
        flag = 0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        repeat (TMO - 1) begin
            tick();
            if (timeout_pulse !== 1'b0 || grant !== 3'b100) flag = 1;
        end
        chk("tmo_quiet", 32'(flag), 32'd0);
        tick();
        chk("tmo_pulse", 32'(timeout_pulse), 32'd1);
        chk("tmo_release", 32'(grant), 32'd0);
        tick();
        chk("tmo_pulse_single", 32'(timeout_pulse), 32'd0);
`else
        repeat (4 * TMO) begin
            tick();
            if (timeout_pulse !== 1'b0 || grant !== 3'b100) flag = 1;
        end
        chk("hold_kept", 32'(flag), 32'd0);
`endif
        hold = '0;
        run_idle("hold", 500);
        cmp_log("hold");

        // Randomized packet mixes
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) begin
                int np;
                np = int'($urandom_range(0, 2));
                for (int p = 0; p < np; p++) begin
                    int len;
                    len = int'($urandom_range(1, 7));
                    for (int b = 0; b < len; b++)
                        src_q.push_back({2'(i),
                                         (b == len - 1) && (p < np - 1 || $urandom_range(0, 1) == 1),
                                         8'($urandom)});
                end
            end
            if (src_q.size() == 0) push_bytes(0, 1, 8'hEE, 1);
            scenario("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin packet arbiter that shares one uart_transmitter (data_in/send/busy/done handshake) between N internal byte-stream requesters, e.g. systolic-array result dump, status/heartbeat, command ACK.
- Grants one requester for a whole packet, feeds its bytes one at a time into the transmitter, then rotates priority.
- Sits between the requesters and the uart_transmitter instance at the UART top level.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- MAX_PKT_BYTES, 64, bytes sent per grant before forced release (fairness cap); 0 means no cap.
- TIMEOUT_CYCLES, 50000, idle-owner timeout in clocks; used only with the optional feature.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  requester i wants the link; held high for the whole packet
- byte_valid  in  N_REQ  requester i presents a byte
- byte_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i]
- byte_last  in  N_REQ  the presented byte ends the packet
- byte_ready  out  N_REQ  arbiter accepts a byte from i this cycle
- grant  out  N_REQ  one-hot current owner; 0 when idle
- owner_id  out  $clog2(N_REQ)  index of the current owner; 0 when idle
- arb_busy  out  1  any grant active
- tx_data  out  8  to uart_transmitter data_in
- tx_send  out  1  one-cycle send strobe to the transmitter
- tx_busy  in  1  transmitter busy
- tx_done  in  1  transmitter frame-complete pulse
- timeout_pulse  out  1  one-cycle owner timeout flag; tied 0 when the feature is disabled

Behaviour:
- One clock domain (clk). Synchronous active-high reset. All outputs are registered except byte_ready.
- Reset values: grant=0, owner_id=0, arb_busy=0, tx_data=0x00, tx_send=0, timeout_pulse=0, byte count=0, state IDLE. The round-robin pointer resets so index 0 has the highest priority.
- States: IDLE, OWN, SEND, WAIT_DONE.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from (last_owner+1) mod N_REQ.
  - grant, owner_id and arb_busy are registered and valid the next cycle; go to OWN.
  - Arbitration takes 1 cycle.
- OWN:
  - byte_ready[i] = (state==OWN) && (owner==i). It is a function of state only, never of byte_valid.
  - A byte transfers when byte_valid[owner] && byte_ready[owner]. On transfer: tx_data <= byte_data[owner], store byte_last, increment byte count, go to SEND.
  - If req[owner] falls with no transfer in that cycle: release the grant, go to IDLE.
  - byte_valid and byte_data from non-owners are ignored.
- SEND:
  - When tx_busy==0: tx_send <= 1 for exactly one cycle, go to WAIT_DONE.
  - While tx_busy==1: stay in SEND; tx_send stays 0 and tx_data is held.
- WAIT_DONE, on tx_done:
  - Release if stored last==1, or if MAX_PKT_BYTES!=0 and byte count==MAX_PKT_BYTES.
  - Release means: grant=0, last_owner=owner, byte count cleared, go to IDLE.
  - Otherwise return to OWN.
  - A forced-release requester that still holds req re-competes normally.
- tx_done outside WAIT_DONE is ignored.
- req rising for the owner during SEND or WAIT_DONE has no effect. req falling during SEND or WAIT_DONE is ignored until the in-flight byte completes.
- Byte count width is $clog2(MAX_PKT_BYTES+1). The round-robin search wraps from N_REQ-1 to 0.
- Throughput: transfer to tx_send takes 2 cycles minimum (OWN→SEND, then strobe).
- Reset asserted in any state returns to reset values on the next edge. Any frame already started is the transmitter's concern.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Enabled:
  - In OWN, a counter increments each cycle with no transfer and clears on transfer or on leaving OWN.
  - When it reaches TIMEOUT_CYCLES: timeout_pulse=1 for one cycle, grant released, last_owner=owner, go to IDLE.
- Disabled: no counter; timeout_pulse is constant 0; an owner may hold OWN indefinitely while req is high.

Test Plan:
- Single packet: N_REQ=3. req[0] sends 0x41, 0x42, 0x43 (last on 0x43); the transmitter model takes 20 cycles per frame. Required: three tx_send pulses with tx_data 0x41/0x42/0x43 in order; grant=3'b001 throughout; grant=0 one cycle after the third tx_done.
- Round-robin: after reset, req[0] and req[2] rise together, each sending 1-byte packets. Required order of grants: 0 then 2. Then req[0] and req[1] rise after owner 2: 0 wins. Then req[0] and req[2] rise after owner 0: 2 wins.
- Fairness cap: MAX_PKT_BYTES=4; req[1] streams 6 bytes with no last while req[2] is pending. Required: grant moves to 2 after the 4th tx_done; after 2 finishes, 1 is re-granted and sends bytes 5 and 6.
- Busy stall: tx_busy forced high for 100 cycles while in SEND. Required: tx_send=0 and tx_data stable the whole time; a single tx_send pulse the cycle after tx_busy falls.
- Reset mid-packet: reset=1 for 1 cycle during WAIT_DONE of owner 1. Required next cycle: grant=0, tx_send=0, arb_busy=0. With req[0] and req[1] both high afterwards, 0 is granted.
- Timeout (UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10): owner 2 holds req with no valid. Required: timeout_pulse high exactly 1 cycle after 10 idle cycles in OWN, grant=0 the same cycle; with the macro undefined, grant stays held.
